rv32m_mdu: RTL



---
 rtl/rv32m_pkg.sv | 27 ++
 rtl/mdu_div_core.sv | 52 +++++
 rtl/rv32m_mdu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} mdu_state_t;

  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM.
  function automatic logic op_signed_a(input logic [2:0] f);
    return (f == F3_MULH) | (f == F3_MULHSU) | (f == F3_DIV) | (f == F3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f);
    return (f == F3_MULH) | (f == F3_DIV) | (f == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring unsigned divider: one quotient bit per enabled cycle on a 33-bit partial remainder.
module mdu_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN:0]   prem_q, prem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN+1:0] trial, diff;

  always_comb begin
    trial  = {prem_q, quo_q[XLEN-1]};
    diff   = trial - {2'b00, divisor};
    prem_d = prem_q;
    quo_d  = quo_q;
    if (load) begin
      prem_d = '0;
      quo_d  = dividend;
    end else if (en) begin
      // Negative trial difference means restore the shifted remainder.
      if (diff[XLEN+1]) begin
        prem_d = trial[XLEN:0];
        quo_d  = {quo_q[XLEN-2:0], 1'b0};
      end else begin
        prem_d = diff[XLEN:0];
        quo_d  = {quo_q[XLEN-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prem_q <= '0;
      quo_q  <= '0;
    end else begin
      prem_q <= prem_d;
      quo_q  <= quo_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = prem_q[XLEN-1:0];

endmodule

// File: rtl/rv32m_mdu.sv
// Iterative RV32M multiply/divide unit with one-cycle register-file write-back.
// Define RV32M_MDU_FAST_MUL_EN to resolve all multiplies combinationally at accept.
module rv32m_mdu
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  mdu_state_t        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, is_div, sgn_a, sgn_b, div_zero, div_ovf, short_path;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, short_res, fix_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_quo, div_rem, quo_s, rem_s;

  assign accept = start & ((state_q == StIdle) | (state_q == StDone));
  assign is_div = funct3[2];
  assign sgn_a  = op_signed_a(funct3) & opa[XLEN-1];
  assign sgn_b  = op_signed_b(funct3) & opb[XLEN-1];
  assign abs_a  = sgn_a ? -opa : opa;
  assign abs_b  = sgn_b ? -opb : opb;

  assign div_zero = is_div & (opb == '0);
  assign div_ovf  = ((funct3 == F3_DIV) | (funct3 == F3_REM)) & (opa == INT_MIN) & (opb == '1);

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    if (div_zero) special_res = funct3[1] ? opa : DIV0_Q;
    else          special_res = funct3[1] ? '0 : INT_MIN;
  end

`ifdef RV32M_MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic [XLEN-1:0]          fast_res;
  assign fast_a   = {{XLEN{sgn_a}}, opa};
  assign fast_b   = {{XLEN{sgn_b}}, opb};
  assign fast_p   = fast_a * fast_b;
  assign fast_res = (funct3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

  always_comb begin
    short_path = div_zero | div_ovf;
    short_res  = special_res;
`ifdef RV32M_MDU_FAST_MUL_EN
    if (!is_div) begin
      short_path = 1'b1;
      short_res  = fast_res;
    end
`endif
  end

  mdu_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       ((state_q == StCalc) & f3_q[2]),
    .dividend (abs_a),
    .divisor  (mag_b_q),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Shift-add: accumulator holds {partial high, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);

  always_comb begin
    prod    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_s   = (neg_a_q ^ neg_b_q) ? -div_quo : div_quo;
    rem_s   = neg_a_q ? -div_rem : div_rem;
    if (f3_q[2])             fix_res = f3_q[1] ? rem_s : quo_s;
    else if (f3_q == F3_MUL) fix_res = prod[XLEN-1:0];
    else                     fix_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (accept) begin
      cnt_d   = '0;
      f3_d    = funct3;
      rd_d    = rd_in;
      mag_a_d = abs_a;
      mag_b_d = abs_b;
      neg_a_d = sgn_a;
      neg_b_d = sgn_b;
      acc_d   = {{XLEN{1'b0}}, abs_b};
      if (short_path) result_d = short_res;
    end else if (state_q == StCalc) begin
      cnt_d = cnt_q + 5'd1;
      if (!f3_q[2]) acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end else if (state_q == StFixup) begin
      result_d = fix_res;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) state_d = short_path ? StDone : StCalc;
        else        state_d = StIdle;
      end
      StCalc:  if (cnt_q == 5'd31) state_d = StFixup;
      StFixup: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StCalc) | (state_q == StFixup);
    done = (state_q == StDone);
    we   = done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign rd_out = rd_q;

endmodule
